quad_corner_tracker: RTL and testbench

//  Per-frame tracker for one colour-keyed quadrilateral (e.g. orange card) in the VGA pixel stream.

---
 rtl/quad_corner_tracker.sv | 263 ++++++++++++++++++++++++++
 tb/tb_quad_corner_tracker.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/quad_corner_tracker.sv
// Per-frame colour-keyed quadrilateral tracker: gathers the four extreme points of qualified
// pixels, classifies the target's tilt, debounces the class and publishes corners on every frame end.
module quad_corner_tracker #(
  parameter int X_W           = 10,
  parameter int Y_W           = 10,
  parameter int H_MAX         = 639,
  parameter int V_MAX         = 479,
  parameter int CNT_W         = 11,
  parameter int STABLE_FRAMES = 2,
  parameter int MISS_FRAMES   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             VGA_VS,
  input  logic             pixel_valid,
  input  logic [X_W-1:0]   pixel_x,
  input  logic [Y_W-1:0]   pixel_y,
  input  logic [7:0]       Cb,
  input  logic [7:0]       Cr,
  input  logic [7:0]       cb_max,
  input  logic [7:0]       cr_min,
  input  logic [CNT_W-1:0] edge_thresh,
  output logic [X_W-1:0]   tl_x,
  output logic [Y_W-1:0]   tl_y,
  output logic [X_W-1:0]   tr_x,
  output logic [Y_W-1:0]   tr_y,
  output logic [X_W-1:0]   bl_x,
  output logic [Y_W-1:0]   bl_y,
  output logic [X_W-1:0]   br_x,
  output logic [Y_W-1:0]   br_y,
  output logic [1:0]       orient,
  output logic             target_valid,
  output logic             frame_done
);

  localparam logic [X_W-1:0]   X_LAST  = X_W'(H_MAX);
  localparam logic [Y_W-1:0]   Y_LAST  = Y_W'(V_MAX);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;
  localparam int               SC_W    = $clog2(STABLE_FRAMES + 1);
  localparam int               MC_W    = $clog2(MISS_FRAMES + 1);
  localparam logic [SC_W-1:0]  STABLE_N = SC_W'(STABLE_FRAMES);
  localparam logic [MC_W-1:0]  MISS_N   = MC_W'(MISS_FRAMES);

  typedef enum logic {WAIT_SOF, TRACK} state_t;
  typedef enum logic [1:0] {ALIGNED = 2'd0, TILT_CW = 2'd1, TILT_CCW = 2'd2, NONE = 2'd3} class_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c == CNT_SAT) ? c : c + CNT_W'(1);
  endfunction

  state_t state, state_next;
  logic   vs_prev;
  logic   vs_fall, qualified, accept, evaluate;

  assign vs_fall   = vs_prev & ~VGA_VS;
  assign qualified = pixel_valid & (Cb < cb_max) & (Cr > cr_min) &
                     (pixel_x <= X_LAST) & (pixel_y <= Y_LAST);
  assign accept    = (state == TRACK) & ~vs_fall & qualified;
  assign evaluate  = (state == TRACK) & vs_fall;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= WAIT_SOF;
      vs_prev <= 1'b0;
    end else begin
      state   <= state_next;
      vs_prev <= VGA_VS;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_SOF: if (vs_fall) state_next = TRACK;
      TRACK:    state_next = TRACK;
      default:  state_next = WAIT_SOF;
    endcase
  end

  // Only the half of each perpendicular extent that feeds a corner point is kept.
  logic [X_W-1:0]   xmin_pos, xmin_pos_n, xmax_pos, xmax_pos_n;
  logic [Y_W-1:0]   xmin_lo, xmin_lo_n, xmax_hi, xmax_hi_n;
  logic [Y_W-1:0]   ymin_pos, ymin_pos_n, ymax_pos, ymax_pos_n;
  logic [X_W-1:0]   ymin_lo, ymin_lo_n, ymax_hi, ymax_hi_n;
  logic [CNT_W-1:0] xmin_cnt, xmin_cnt_n, xmax_cnt, xmax_cnt_n;
  logic [CNT_W-1:0] ymin_cnt, ymin_cnt_n, ymax_cnt, ymax_cnt_n;
  logic             any_hit, any_hit_n;

  always_comb begin
    xmin_pos_n = xmin_pos;  xmin_lo_n = xmin_lo;  xmin_cnt_n = xmin_cnt;
    xmax_pos_n = xmax_pos;  xmax_hi_n = xmax_hi;  xmax_cnt_n = xmax_cnt;
    ymin_pos_n = ymin_pos;  ymin_lo_n = ymin_lo;  ymin_cnt_n = ymin_cnt;
    ymax_pos_n = ymax_pos;  ymax_hi_n = ymax_hi;  ymax_cnt_n = ymax_cnt;
    any_hit_n  = any_hit;
    if (vs_fall) begin
      xmin_pos_n = X_LAST;  xmin_lo_n = Y_LAST;  xmin_cnt_n = '0;
      xmax_pos_n = '0;      xmax_hi_n = '0;      xmax_cnt_n = '0;
      ymin_pos_n = Y_LAST;  ymin_lo_n = X_LAST;  ymin_cnt_n = '0;
      ymax_pos_n = '0;      ymax_hi_n = '0;      ymax_cnt_n = '0;
      any_hit_n  = 1'b0;
    end else if (accept) begin
      any_hit_n = 1'b1;
      if (pixel_x < xmin_pos) begin
        xmin_pos_n = pixel_x;
        xmin_lo_n  = pixel_y;
        xmin_cnt_n = CNT_W'(1);
      end else if (pixel_x == xmin_pos) begin
        if (pixel_y < xmin_lo) xmin_lo_n = pixel_y;
        xmin_cnt_n = sat_inc(xmin_cnt);
      end
      if (pixel_x > xmax_pos) begin
        xmax_pos_n = pixel_x;
        xmax_hi_n  = pixel_y;
        xmax_cnt_n = CNT_W'(1);
      end else if (pixel_x == xmax_pos) begin
        if (pixel_y > xmax_hi) xmax_hi_n = pixel_y;
        xmax_cnt_n = sat_inc(xmax_cnt);
      end
      if (pixel_y < ymin_pos) begin
        ymin_pos_n = pixel_y;
        ymin_lo_n  = pixel_x;
        ymin_cnt_n = CNT_W'(1);
      end else if (pixel_y == ymin_pos) begin
        if (pixel_x < ymin_lo) ymin_lo_n = pixel_x;
        ymin_cnt_n = sat_inc(ymin_cnt);
      end
      if (pixel_y > ymax_pos) begin
        ymax_pos_n = pixel_y;
        ymax_hi_n  = pixel_x;
        ymax_cnt_n = CNT_W'(1);
      end else if (pixel_y == ymax_pos) begin
        if (pixel_x > ymax_hi) ymax_hi_n = pixel_x;
        ymax_cnt_n = sat_inc(ymax_cnt);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      xmin_pos <= X_LAST;  xmin_lo <= Y_LAST;  xmin_cnt <= '0;
      xmax_pos <= '0;      xmax_hi <= '0;      xmax_cnt <= '0;
      ymin_pos <= Y_LAST;  ymin_lo <= X_LAST;  ymin_cnt <= '0;
      ymax_pos <= '0;      ymax_hi <= '0;      ymax_cnt <= '0;
      any_hit  <= 1'b0;
    end else begin
      xmin_pos <= xmin_pos_n;  xmin_lo <= xmin_lo_n;  xmin_cnt <= xmin_cnt_n;
      xmax_pos <= xmax_pos_n;  xmax_hi <= xmax_hi_n;  xmax_cnt <= xmax_cnt_n;
      ymin_pos <= ymin_pos_n;  ymin_lo <= ymin_lo_n;  ymin_cnt <= ymin_cnt_n;
      ymax_pos <= ymax_pos_n;  ymax_hi <= ymax_hi_n;  ymax_cnt <= ymax_cnt_n;
      any_hit  <= any_hit_n;
    end
  end

  class_t          adopted, adopted_n, cand_class, cand_class_n, raw_class;
  logic [SC_W-1:0] cand_cnt, cand_cnt_n, cand_inc;
  logic [MC_W-1:0] miss_cnt, miss_inc;
  logic            edge_flat;
  logic [X_W:0]    x_sum;
  logic [X_W-1:0]  x_mid;

  assign edge_flat = (xmin_cnt > edge_thresh) | (xmax_cnt > edge_thresh) |
                     (ymin_cnt > edge_thresh) | (ymax_cnt > edge_thresh);
  assign x_sum     = {1'b0, xmin_pos} + {1'b0, xmax_pos};
  assign x_mid     = x_sum[X_W:1];
  assign miss_inc  = (miss_cnt == MISS_N) ? miss_cnt : miss_cnt + MC_W'(1);

  // A tie between the topmost x and the horizontal midpoint keeps the current decision.
  always_comb begin
    raw_class = ALIGNED;
    if (edge_flat)            raw_class = ALIGNED;
    else if (ymin_lo < x_mid) raw_class = TILT_CW;
    else if (ymin_lo > x_mid) raw_class = TILT_CCW;
    else                      raw_class = (adopted == NONE) ? ALIGNED : adopted;
  end

  always_comb begin
    adopted_n    = adopted;
    cand_class_n = cand_class;
    cand_cnt_n   = cand_cnt;
    cand_inc     = SC_W'(1);
    if (raw_class == adopted) begin
      cand_cnt_n = '0;
    end else begin
      if ((cand_cnt != '0) && (raw_class == cand_class)) cand_inc = cand_cnt + SC_W'(1);
      cand_class_n = raw_class;
      if (cand_inc >= STABLE_N) begin
        adopted_n  = raw_class;
        cand_cnt_n = '0;
      end else begin
        cand_cnt_n = cand_inc;
      end
    end
  end

  logic [X_W-1:0] map_tl_x, map_tr_x, map_bl_x, map_br_x;
  logic [Y_W-1:0] map_tl_y, map_tr_y, map_bl_y, map_br_y;

  // Until a class has been adopted there is no meaningful mapping, so corners hold.
  always_comb begin
    map_tl_x = tl_x;  map_tl_y = tl_y;
    map_tr_x = tr_x;  map_tr_y = tr_y;
    map_bl_x = bl_x;  map_bl_y = bl_y;
    map_br_x = br_x;  map_br_y = br_y;
    case (adopted_n)
      ALIGNED: begin
        map_tl_x = xmin_pos;  map_tl_y = ymin_pos;
        map_tr_x = xmax_pos;  map_tr_y = ymin_pos;
        map_bl_x = xmin_pos;  map_bl_y = ymax_pos;
        map_br_x = xmax_pos;  map_br_y = ymax_pos;
      end
      TILT_CW: begin
        map_tl_x = ymin_lo;   map_tl_y = ymin_pos;
        map_tr_x = xmax_pos;  map_tr_y = xmax_hi;
        map_br_x = ymax_hi;   map_br_y = ymax_pos;
        map_bl_x = xmin_pos;  map_bl_y = xmin_lo;
      end
      TILT_CCW: begin
        map_tl_x = xmin_pos;  map_tl_y = xmin_lo;
        map_tr_x = ymin_lo;   map_tr_y = ymin_pos;
        map_br_x = xmax_pos;  map_br_y = xmax_hi;
        map_bl_x = ymax_hi;   map_bl_y = ymax_pos;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tl_x <= '0;  tl_y <= '0;  tr_x <= '0;  tr_y <= '0;
      bl_x <= '0;  bl_y <= '0;  br_x <= '0;  br_y <= '0;
      orient       <= NONE;
      target_valid <= 1'b0;
      frame_done   <= 1'b0;
      adopted      <= NONE;
      cand_class   <= NONE;
      cand_cnt     <= '0;
      miss_cnt     <= '0;
    end else begin
      frame_done <= evaluate;
      if (evaluate) begin
        if (any_hit) begin
          adopted      <= adopted_n;
          cand_class   <= cand_class_n;
          cand_cnt     <= cand_cnt_n;
          tl_x <= map_tl_x;  tl_y <= map_tl_y;
          tr_x <= map_tr_x;  tr_y <= map_tr_y;
          bl_x <= map_bl_x;  bl_y <= map_bl_y;
          br_x <= map_br_x;  br_y <= map_br_y;
          orient       <= adopted_n;
          target_valid <= 1'b1;
          miss_cnt     <= '0;
        end else begin
          miss_cnt <= miss_inc;
          if (miss_inc == MISS_N) begin
            target_valid <= 1'b0;
            orient       <= NONE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_quad_corner_tracker.sv
// Self-checking bench for quad_corner_tracker: directed shapes plus random frames, compared
// against a set-based frame model (extremes found by scanning each frame's pixel list).
module tb_quad_corner_tracker;
  localparam int X_W = 10, Y_W = 10, H_MAX = 639, V_MAX = 479, CNT_W = 11;
  localparam int STABLE = 2, MISS = 4, CNT_SAT = 2047;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset = 1'b0, VGA_VS = 1'b0, pixel_valid = 1'b0;
  logic [X_W-1:0]   pixel_x = '0;
  logic [Y_W-1:0]   pixel_y = '0;
  logic [7:0]       Cb = '0, Cr = '0, cb_max = 8'd128, cr_min = 8'd128;
  logic [CNT_W-1:0] edge_thresh = 11'd10;
  logic [X_W-1:0]   tl_x, tr_x, bl_x, br_x;
  logic [Y_W-1:0]   tl_y, tr_y, bl_y, br_y;
  logic [1:0]       orient;
  logic             target_valid, frame_done;

  quad_corner_tracker #(.X_W(X_W), .Y_W(Y_W), .H_MAX(H_MAX), .V_MAX(V_MAX), .CNT_W(CNT_W),
                        .STABLE_FRAMES(STABLE), .MISS_FRAMES(MISS)) dut (
    .clk(clk), .reset(reset), .VGA_VS(VGA_VS), .pixel_valid(pixel_valid),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .Cb(Cb), .Cr(Cr), .cb_max(cb_max), .cr_min(cr_min),
    .edge_thresh(edge_thresh), .tl_x(tl_x), .tl_y(tl_y), .tr_x(tr_x), .tr_y(tr_y),
    .bl_x(bl_x), .bl_y(bl_y), .br_x(br_x), .br_y(br_y), .orient(orient),
    .target_valid(target_valid), .frame_done(frame_done));

  int n_checks = 0, n_fail = 0;

  int m_tl_x, m_tl_y, m_tr_x, m_tr_y, m_bl_x, m_bl_y, m_br_x, m_br_y;
  int m_orient, m_tv, m_adopted, m_cand, m_cand_cnt, m_miss;
  bit m_tracking;
  int qx[$], qy[$];

  task automatic checkOutput(string tag, logic [31:0] observed, logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkAll();
    checkOutput("tl_x", 32'(tl_x), m_tl_x);  checkOutput("tl_y", 32'(tl_y), m_tl_y);
    checkOutput("tr_x", 32'(tr_x), m_tr_x);  checkOutput("tr_y", 32'(tr_y), m_tr_y);
    checkOutput("bl_x", 32'(bl_x), m_bl_x);  checkOutput("bl_y", 32'(bl_y), m_bl_y);
    checkOutput("br_x", 32'(br_x), m_br_x);  checkOutput("br_y", 32'(br_y), m_br_y);
    checkOutput("orient", 32'(orient), m_orient);
    checkOutput("target_valid", 32'(target_valid), m_tv);
  endtask

  task automatic modelReset();
    {m_tl_x, m_tl_y, m_tr_x, m_tr_y, m_bl_x, m_bl_y, m_br_x, m_br_y} = '0;
    m_orient = 3; m_adopted = 3; m_cand = 3; m_cand_cnt = 0;
    m_tv = 0; m_miss = 0; m_tracking = 1'b0;
    qx.delete(); qy.delete();
  endtask

  // Whole-frame evaluation from the list of qualified pixels.
  task automatic modelEval();
    int xmin, xmax, ymin, ymax, left_y, right_y, top_x, bot_x;
    int c_l, c_r, c_t, c_b, raw, mid;
    if (qx.size() == 0) begin
      if (m_miss < MISS) m_miss++;
      if (m_miss == MISS) begin m_tv = 0; m_orient = 3; end
      return;
    end
    xmin = 100000; xmax = -1; ymin = 100000; ymax = -1;
    foreach (qx[i]) begin
      if (qx[i] < xmin) xmin = qx[i];
      if (qx[i] > xmax) xmax = qx[i];
      if (qy[i] < ymin) ymin = qy[i];
      if (qy[i] > ymax) ymax = qy[i];
    end
    left_y = 100000; right_y = -1; top_x = 100000; bot_x = -1;
    c_l = 0; c_r = 0; c_t = 0; c_b = 0;
    foreach (qx[i]) begin
      if (qx[i] == xmin) begin c_l++; if (qy[i] < left_y)  left_y  = qy[i]; end
      if (qx[i] == xmax) begin c_r++; if (qy[i] > right_y) right_y = qy[i]; end
      if (qy[i] == ymin) begin c_t++; if (qx[i] < top_x)   top_x   = qx[i]; end
      if (qy[i] == ymax) begin c_b++; if (qx[i] > bot_x)   bot_x   = qx[i]; end
    end
    if (c_l > CNT_SAT) c_l = CNT_SAT;
    if (c_r > CNT_SAT) c_r = CNT_SAT;
    if (c_t > CNT_SAT) c_t = CNT_SAT;
    if (c_b > CNT_SAT) c_b = CNT_SAT;
    mid = (xmin + xmax) / 2;
    if (c_l > int'(edge_thresh) || c_r > int'(edge_thresh) ||
        c_t > int'(edge_thresh) || c_b > int'(edge_thresh)) raw = 0;
    else if (top_x < mid) raw = 1;
    else if (top_x > mid) raw = 2;
    else raw = (m_adopted == 3) ? 0 : m_adopted;
    if (raw == m_adopted) m_cand_cnt = 0;
    else begin
      if (m_cand_cnt > 0 && raw == m_cand) m_cand_cnt++;
      else begin m_cand = raw; m_cand_cnt = 1; end
      if (m_cand_cnt >= STABLE) begin m_adopted = raw; m_cand_cnt = 0; end
    end
    case (m_adopted)
      0: begin m_tl_x = xmin; m_tl_y = ymin; m_tr_x = xmax; m_tr_y = ymin;
               m_bl_x = xmin; m_bl_y = ymax; m_br_x = xmax; m_br_y = ymax; end
      1: begin m_tl_x = top_x; m_tl_y = ymin; m_tr_x = xmax; m_tr_y = right_y;
               m_br_x = bot_x; m_br_y = ymax; m_bl_x = xmin; m_bl_y = left_y; end
      2: begin m_tl_x = xmin; m_tl_y = left_y; m_tr_x = top_x; m_tr_y = ymin;
               m_br_x = xmax; m_br_y = right_y; m_bl_x = bot_x; m_bl_y = ymax; end
      default: ;
    endcase
    m_orient = m_adopted; m_tv = 1; m_miss = 0;
  endtask

  task automatic applyStimulus(int x, int y, int cb, int cr, bit valid);
    @(negedge clk);
    pixel_valid = valid; pixel_x = x[X_W-1:0]; pixel_y = y[Y_W-1:0];
    Cb = cb[7:0]; Cr = cr[7:0];
    if (m_tracking && valid && cb < int'(cb_max) && cr > int'(cr_min) && x <= H_MAX && y <= V_MAX) begin
      qx.push_back(x); qy.push_back(y);
    end
  endtask

  task automatic endFrame(bit vs_pixel);
    bit was_tracking;
    @(negedge clk);
    pixel_valid = 1'b0; VGA_VS = 1'b1;
    @(negedge clk);
    VGA_VS = 1'b0;
    if (vs_pixel) begin pixel_valid = 1'b1; pixel_x = 10'd5; pixel_y = 10'd5; Cb = 8'd0; Cr = 8'd255; end
    was_tracking = m_tracking;
    if (m_tracking) modelEval(); else m_tracking = 1'b1;
    qx.delete(); qy.delete();
    @(negedge clk);
    pixel_valid = 1'b0;
    checkOutput("frame_done", 32'(frame_done), 32'(was_tracking));
    if (was_tracking) checkAll();
    @(negedge clk);
    checkOutput("frame_done_pulse", 32'(frame_done), 0);
  endtask

  task automatic drawSquare();
    for (int i = 0; i < 100; i++) begin
      applyStimulus(100 + i, 50, 60, 200, 1'b1);
      applyStimulus(100 + i, 149, 60, 200, 1'b1);
      applyStimulus(100, 50 + i, 60, 200, 1'b1);
      applyStimulus(199, 50 + i, 60, 200, 1'b1);
    end
    applyStimulus(10, 10, 200, 200, 1'b1);
    applyStimulus(20, 20, 60, 200, 1'b0);
    applyStimulus(30, 30, 60, 100, 1'b1);
  endtask

  task automatic drawQuad(int tx, int ty, int rx, int ry, int bx, int by, int lx, int ly);
    applyStimulus(tx, ty, 60, 200, 1'b1);
    applyStimulus(rx, ry, 60, 200, 1'b1);
    applyStimulus(bx, by, 60, 200, 1'b1);
    applyStimulus(lx, ly, 60, 200, 1'b1);
  endtask

  initial begin
    modelReset();
    reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("reset_frame_done", 32'(frame_done), 0);
    end
    checkAll();
    @(negedge clk); reset = 1'b1;
    endFrame(1'b0);

    // Axis-aligned square, adopted on the second frame.
    drawSquare(); endFrame(1'b0);
    checkOutput("sq1_orient", 32'(orient), 3);
    drawSquare(); endFrame(1'b0);
    checkOutput("sq2_tl_x", 32'(tl_x), 100); checkOutput("sq2_tl_y", 32'(tl_y), 50);
    checkOutput("sq2_br_x", 32'(br_x), 199); checkOutput("sq2_br_y", 32'(br_y), 149);
    checkOutput("sq2_orient", 32'(orient), 0);

    // Clockwise-tilted frames interleaved with aligned frames never reach the stability depth.
    for (int k = 0; k < 2; k++) begin
      drawQuad(120, 40, 220, 100, 180, 180, 80, 120); endFrame(1'b0);
      checkOutput("alt_cw_orient", 32'(orient), 0);
      drawSquare(); endFrame(1'b0);
      checkOutput("alt_sq_orient", 32'(orient), 0);
    end

    // Diamond with a flat three-pixel top right of the midpoint: counter-clockwise after two frames.
    for (int k = 0; k < 2; k++) begin
      drawQuad(156, 40, 220, 110, 150, 180, 80, 110);
      applyStimulus(157, 40, 60, 200, 1'b1);
      applyStimulus(158, 40, 60, 200, 1'b1);
      endFrame(1'b0);
    end
    checkOutput("dia_orient", 32'(orient), 2);
    checkOutput("dia_tl_x", 32'(tl_x), 80);  checkOutput("dia_tr_x", 32'(tr_x), 156);
    checkOutput("dia_bl_y", 32'(bl_y), 180);

    // Empty frames: x beyond the frame and off-colour pixels never count.
    for (int k = 1; k <= MISS; k++) begin
      applyStimulus(640, 100, 60, 200, 1'b1);
      applyStimulus(150, 100, 60, 128, 1'b1);
      endFrame(1'b0);
      checkOutput("miss_tv", 32'(target_valid), (k < MISS) ? 1 : 0);
      checkOutput("miss_tl_x", 32'(tl_x), 80);
    end

    // A qualified pixel during the VS falling cycle must not leak into the next frame.
    drawSquare(); applyStimulus(640, 60, 60, 200, 1'b1); endFrame(1'b1);
    drawSquare(); endFrame(1'b0);
    checkOutput("vs_pix_tl_x", 32'(tl_x), 100); checkOutput("vs_pix_orient", 32'(orient), 0);

    // Random frames.
    cr_min = 8'd100;
    for (int f = 0; f < 10; f++) begin
      int n;
      edge_thresh = 11'($urandom_range(0, 3));
      n = (f % 4 == 3) ? 0 : $urandom_range(1, 30);
      for (int i = 0; i < n; i++)
        applyStimulus($urandom_range(0, 700), $urandom_range(0, 520),
                      $urandom_range(0, 160), $urandom_range(80, 255), ($urandom_range(0, 3) != 0));
      endFrame($urandom_range(0, 1) == 1);
    end

    // Mid-frame reset discards the frame and clears all outputs.
    cr_min = 8'd128; edge_thresh = 11'd10;
    drawQuad(120, 40, 220, 100, 180, 180, 80, 120);
    @(negedge clk); reset = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checkOutput("midrst_frame_done", 32'(frame_done), 0);
    end
    modelReset();
    checkAll();
    @(negedge clk); reset = 1'b1;
    endFrame(1'b0);
    drawSquare(); endFrame(1'b0);
    drawSquare(); endFrame(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
